// File: rtl/axi4_fifo_mgr_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) with manager and subordinate views.
interface axi4_bus_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned USER_W = 1
) ();
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic              aw_lock;
  logic [3:0]        aw_cache;
  logic [2:0]        aw_prot;
  logic [3:0]        aw_qos;
  logic [3:0]        aw_region;
  logic [5:0]        aw_atop;
  logic [USER_W-1:0] aw_user;
  logic              aw_valid;
  logic              aw_ready;

  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              w_last;
  logic [USER_W-1:0] w_user;
  logic              w_valid;
  logic              w_ready;

  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;
  logic [USER_W-1:0] b_user;
  logic              b_valid;
  logic              b_ready;

  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              ar_lock;
  logic [3:0]        ar_cache;
  logic [2:0]        ar_prot;
  logic [3:0]        ar_qos;
  logic [3:0]        ar_region;
  logic [USER_W-1:0] ar_user;
  logic              ar_valid;
  logic              ar_ready;

  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic [USER_W-1:0] r_user;
  logic              r_valid;
  logic              r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi4_fifo_mgr.sv
// AXI4 manager: drains the write FIFO as one INCR burst and fills the read FIFO
// from one INCR burst; write and read sides run independently.
module axi4_fifo_mgr #(
  parameter int unsigned AXI_ADDR_WIDTH   = 32,
  parameter int unsigned AXI_DATA_WIDTH   = 64,
  parameter int unsigned AXI_XSIZE        = 8,
  parameter int unsigned DATA_COUNT_WIDTH = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  req_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_wr_addr_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_rd_addr_i,
  input  logic                        wr_fifo_gnt_i,
  input  logic                        rd_fifo_req_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wr_fifo_data_i,
  input  logic [DATA_COUNT_WIDTH-1:0] wr_data_count_i,
  input  logic [DATA_COUNT_WIDTH-1:0] rd_data_count_i,
  output logic [1:0]                  rsp_o,
  output logic [1:0]                  wr_err_o,
  output logic [1:0]                  rd_err_o,
  output logic                        wr_fifo_req_o,
  output logic                        rd_fifo_gnt_o,
  output logic [AXI_DATA_WIDTH-1:0]   rd_fifo_data_o,
  axi4_bus_if.master                  axi_mgr_if
);
  localparam int unsigned AX_SIZE = $clog2(AXI_XSIZE);

  typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;

  wr_state_e                 wr_state_q, wr_state_d;
  rd_state_e                 rd_state_q, rd_state_d;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [7:0]                wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d, rd_len_q, rd_len_d;
  logic [1:0]                wr_err_q, wr_err_d, rd_err_q, rd_err_d;
  logic                      wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic                      w_fire_c, r_fire_c, unused_c;

  // AXI len field for a beat count, saturating at a 256-beat burst.
  function automatic logic [7:0] len_of(input logic [DATA_COUNT_WIDTH-1:0] cnt);
    if (cnt > DATA_COUNT_WIDTH'(255)) return 8'hFF;
    return 8'(cnt - DATA_COUNT_WIDTH'(1));
  endfunction

  assign axi_mgr_if.aw_id     = '0;
  assign axi_mgr_if.aw_addr   = wr_addr_q;
  assign axi_mgr_if.aw_len    = wr_len_q;
  assign axi_mgr_if.aw_size   = 3'(AX_SIZE);
  assign axi_mgr_if.aw_burst  = 2'b01;
  assign axi_mgr_if.aw_lock   = 1'b0;
  assign axi_mgr_if.aw_cache  = '0;
  assign axi_mgr_if.aw_prot   = '0;
  assign axi_mgr_if.aw_qos    = '0;
  assign axi_mgr_if.aw_region = '0;
  assign axi_mgr_if.aw_atop   = '0;
  assign axi_mgr_if.aw_user   = '0;
  assign axi_mgr_if.aw_valid  = (wr_state_q == WR_AW);

  assign axi_mgr_if.w_valid   = (wr_state_q == WR_W) & wr_fifo_gnt_i;
  assign axi_mgr_if.w_data    = (wr_state_q == WR_W) ? wr_fifo_data_i : '0;
  assign axi_mgr_if.w_strb    = '1;
  assign axi_mgr_if.w_last    = (wr_state_q == WR_W) & (wr_cnt_q == wr_len_q);
  assign axi_mgr_if.w_user    = '0;
  assign axi_mgr_if.b_ready   = (wr_state_q == WR_B);

  assign axi_mgr_if.ar_id     = '0;
  assign axi_mgr_if.ar_addr   = rd_addr_q;
  assign axi_mgr_if.ar_len    = rd_len_q;
  assign axi_mgr_if.ar_size   = 3'(AX_SIZE);
  assign axi_mgr_if.ar_burst  = 2'b01;
  assign axi_mgr_if.ar_lock   = 1'b0;
  assign axi_mgr_if.ar_cache  = '0;
  assign axi_mgr_if.ar_prot   = '0;
  assign axi_mgr_if.ar_qos    = '0;
  assign axi_mgr_if.ar_region = '0;
  assign axi_mgr_if.ar_user   = '0;
  assign axi_mgr_if.ar_valid  = (rd_state_q == RD_AR);
  assign axi_mgr_if.r_ready   = (rd_state_q == RD_R) & rd_fifo_req_i;

  // One FIFO pop / push per accepted beat.
  assign w_fire_c       = axi_mgr_if.w_valid & axi_mgr_if.w_ready;
  assign r_fire_c       = axi_mgr_if.r_valid & axi_mgr_if.r_ready;
  assign wr_fifo_req_o  = w_fire_c;
  assign rd_fifo_gnt_o  = r_fire_c;
  assign rd_fifo_data_o = (rd_state_q == RD_R) ? axi_mgr_if.r_data : '0;
  assign rsp_o          = {rd_done_q, wr_done_q};
  assign wr_err_o       = wr_err_q;
  assign rd_err_o       = rd_err_q;
  assign unused_c       = ^{axi_mgr_if.b_id, axi_mgr_if.b_user, axi_mgr_if.r_id, axi_mgr_if.r_user};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      rd_len_q   <= '0;
      wr_err_q   <= '0;
      rd_err_q   <= '0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_len_q   <= rd_len_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
    end
  end

  // Write side: an empty FIFO completes at once without touching the bus.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_cnt_d   = wr_cnt_q;
    wr_err_d   = wr_err_q;
    wr_done_d  = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (req_i[0]) begin
          wr_addr_d = axi_wr_addr_i;
          wr_len_d  = len_of(wr_data_count_i);
          wr_cnt_d  = '0;
          wr_err_d  = '0;
          if (wr_data_count_i == '0) wr_done_d  = 1'b1;
          else                       wr_state_d = WR_AW;
        end
      end
      WR_AW: if (axi_mgr_if.aw_ready) wr_state_d = WR_W;
      WR_W: begin
        if (w_fire_c) begin
          if (axi_mgr_if.w_last) wr_state_d = WR_B;
          else                   wr_cnt_d   = wr_cnt_q + 8'd1;
        end
      end
      WR_B: begin
        if (axi_mgr_if.b_valid) begin
          wr_err_d   = axi_mgr_if.b_resp;
          wr_done_d  = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read side: a zero count still fetches one beat; error keeps the worst RRESP.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    rd_err_d   = rd_err_q;
    rd_done_d  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (req_i[1]) begin
          rd_addr_d  = axi_rd_addr_i;
          rd_len_d   = (rd_data_count_i == '0) ? 8'h00 : len_of(rd_data_count_i);
          rd_err_d   = '0;
          rd_state_d = RD_AR;
        end
      end
      RD_AR: if (axi_mgr_if.ar_ready) rd_state_d = RD_R;
      RD_R: begin
        if (r_fire_c) begin
          if (axi_mgr_if.r_resp > rd_err_q) rd_err_d = axi_mgr_if.r_resp;
          if (axi_mgr_if.r_last) begin
            rd_done_d  = 1'b1;
            rd_state_d = RD_IDLE;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi4_fifo_mgr.sv
// Bench for axi4_fifo_mgr: queue-based FIFO and subordinate models with
// randomized data/backpressure, checked against burst-level expectations.
module tb_axi4_fifo_mgr;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i;
  logic [31:0] axi_wr_addr_i, axi_rd_addr_i;
  logic        wr_fifo_gnt_i, rd_fifo_req_i;
  logic [63:0] wr_fifo_data_i;
  logic [9:0]  wr_data_count_i, rd_data_count_i;
  logic [1:0]  rsp_o, wr_err_o, rd_err_o;
  logic        wr_fifo_req_o, rd_fifo_gnt_o;
  logic [63:0] rd_fifo_data_o;

  axi4_bus_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  axi4_fifo_mgr #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_XSIZE(8), .DATA_COUNT_WIDTH(10)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i),
    .axi_wr_addr_i(axi_wr_addr_i), .axi_rd_addr_i(axi_rd_addr_i),
    .wr_fifo_gnt_i(wr_fifo_gnt_i), .rd_fifo_req_i(rd_fifo_req_i),
    .wr_fifo_data_i(wr_fifo_data_i), .wr_data_count_i(wr_data_count_i),
    .rd_data_count_i(rd_data_count_i), .rsp_o(rsp_o), .wr_err_o(wr_err_o),
    .rd_err_o(rd_err_o), .wr_fifo_req_o(wr_fifo_req_o), .rd_fifo_gnt_o(rd_fifo_gnt_o),
    .rd_fifo_data_o(rd_fifo_data_o), .axi_mgr_if(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  logic [63:0] wq[$], wr_exp[$], w_got[$], r_q[$], r_sent[$], pushed[$];
  logic        w_last_got[$];
  logic [1:0]  r_resp_q[$], r_resp_sent[$];
  logic [31:0] aw_addr_got[$], ar_addr_got[$];
  logic [7:0]  aw_len_got[$], ar_len_got[$];
  logic [2:0]  aw_size_got, ar_size_got;
  logic [1:0]  aw_burst_got, ar_burst_got;
  int          pops, aw_seen, wr_rsp, rd_rsp, rd_stall, rd_stall_arm;
  bit          bp, b_pend, rd_rand_resp, r_hold, aw_stall, w_stall, rst_drv;
  logic [1:0]  b_resp_cfg, req_pend;
  logic [31:0] aw_addr_prev;
  logic [7:0]  aw_len_prev;
  logic [63:0] w_data_prev;
  logic        w_last_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe the cycle just before the rising edge and update the models.
  task automatic sample();
    logic [63:0] d;
    logic [1:0]  rr;
    if (aw_stall) begin
      chk("aw_hold_valid", 64'(bus.aw_valid), 64'd1);
      chk("aw_hold_addr", 64'(bus.aw_addr), 64'(aw_addr_prev));
      chk("aw_hold_len", 64'(bus.aw_len), 64'(aw_len_prev));
    end
    if (bus.aw_valid) aw_seen++;
    if (bus.aw_valid && bus.aw_ready) begin
      aw_addr_got.push_back(bus.aw_addr);
      aw_len_got.push_back(bus.aw_len);
      aw_size_got  = bus.aw_size;
      aw_burst_got = bus.aw_burst;
      chk("aw_const", 64'({bus.aw_id, bus.aw_lock, bus.aw_cache, bus.aw_prot, bus.aw_qos,
                           bus.aw_region, bus.aw_atop, bus.aw_user}), 64'd0);
    end
    aw_stall     = bus.aw_valid && !bus.aw_ready;
    aw_addr_prev = bus.aw_addr;
    aw_len_prev  = bus.aw_len;

    if (w_stall) begin
      chk("w_hold_valid", 64'(bus.w_valid), 64'd1);
      chk("w_hold_data", bus.w_data, w_data_prev);
      chk("w_hold_last", 64'(bus.w_last), 64'(w_last_prev));
    end
    chk("w_pop", 64'(wr_fifo_req_o), 64'(bus.w_valid && bus.w_ready));
    if (bus.w_valid && bus.w_ready) begin
      w_got.push_back(bus.w_data);
      w_last_got.push_back(bus.w_last);
      chk("w_strb", 64'(bus.w_strb), 64'hFF);
      if (bus.w_last) b_pend = 1'b1;
    end
    if (wr_fifo_req_o) begin
      pops++;
      if (wq.size() != 0) void'(wq.pop_front());
    end
    w_stall     = bus.w_valid && !bus.w_ready;
    w_data_prev = bus.w_data;
    w_last_prev = bus.w_last;
    if (bus.b_valid && bus.b_ready) b_pend = 1'b0;

    if (bus.ar_valid && bus.ar_ready) begin
      ar_addr_got.push_back(bus.ar_addr);
      ar_len_got.push_back(bus.ar_len);
      ar_size_got  = bus.ar_size;
      ar_burst_got = bus.ar_burst;
      chk("ar_const", 64'({bus.ar_id, bus.ar_lock, bus.ar_cache, bus.ar_prot, bus.ar_qos,
                           bus.ar_region, bus.ar_user}), 64'd0);
      for (int i = 0; i <= int'(bus.ar_len); i++) begin
        d  = {$urandom, $urandom};
        rr = rd_rand_resp ? 2'($urandom_range(0, 3)) : 2'b00;
        r_q.push_back(d);
        r_resp_q.push_back(rr);
        r_sent.push_back(d);
        r_resp_sent.push_back(rr);
      end
    end
    if (rd_stall > 0) begin
      chk("r_ready_stall", 64'(bus.r_ready), 64'd0);
      rd_stall--;
    end
    if (bus.r_valid && bus.r_ready) begin
      void'(r_q.pop_front());
      void'(r_resp_q.pop_front());
      r_hold = 1'b0;
    end else begin
      r_hold = bus.r_valid;
    end
    if (rd_fifo_gnt_o) begin
      pushed.push_back(rd_fifo_data_o);
      if (rd_stall_arm > 0) begin
        rd_stall     = rd_stall_arm;
        rd_stall_arm = 0;
      end
    end
    if (rsp_o[0]) wr_rsp++;
    if (rsp_o[1]) rd_rsp++;
    if (rst_drv) begin
      b_pend = 1'b0; r_hold = 1'b0; aw_stall = 1'b0; w_stall = 1'b0;
      r_q.delete(); r_resp_q.delete();
    end
  endtask

  // Drive FIFO and subordinate inputs on the falling edge, sample before the rising edge.
  task automatic step();
    @(negedge clk);
    rst_i           = rst_drv;
    req_i           = req_pend;
    req_pend        = 2'b00;
    wr_fifo_gnt_i   = (wq.size() != 0);
    wr_fifo_data_i  = (wq.size() != 0) ? wq[0] : 64'h0;
    wr_data_count_i = 10'(wq.size());
    rd_fifo_req_i   = (rd_stall == 0);
    bus.aw_ready    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.w_ready     = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.ar_ready    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.b_valid     = b_pend;
    bus.b_resp      = b_resp_cfg;
    bus.r_valid     = (r_q.size() != 0) && (r_hold || !bp || ($urandom_range(0, 1) == 1));
    bus.r_data      = (r_q.size() != 0) ? r_q[0] : 64'h0;
    bus.r_resp      = (r_q.size() != 0) ? r_resp_q[0] : 2'b00;
    bus.r_last      = (r_q.size() == 1);
    #4;
    sample();
  endtask

  task automatic wait_done(input int wr0, input int rd0, input bit need_wr, input bit need_rd);
    int t = 0;
    while (((need_wr && wr_rsp == wr0) || (need_rd && rd_rsp == rd0)) && t < 4000) begin
      step();
      t++;
    end
    chk("done_timeout", 64'(t < 4000), 64'd1);
    repeat (4) step();
  endtask

  task automatic wr_prep(input int n, input logic [31:0] addr, input logic [1:0] resp, input bit seq);
    logic [63:0] d;
    aw_addr_got.delete(); aw_len_got.delete(); w_got.delete(); w_last_got.delete();
    wq.delete(); wr_exp.delete();
    pops = 0; aw_seen = 0;
    for (int i = 0; i < n; i++) begin
      d = seq ? 64'(i) : {$urandom, $urandom};
      wq.push_back(d);
      wr_exp.push_back(d);
    end
    b_resp_cfg    = resp;
    axi_wr_addr_i = addr;
  endtask

  task automatic wr_check(input int n, input logic [31:0] addr, input logic [1:0] resp, input int wr0);
    int beats;
    beats = (n > 256) ? 256 : n;
    chk("wr_rsp_pulse", 64'(wr_rsp - wr0), 64'd1);
    chk("wr_err", 64'(wr_err_o), 64'((n == 0) ? 2'b00 : resp));
    chk("aw_count", 64'(aw_addr_got.size()), 64'((n == 0) ? 0 : 1));
    if (n == 0) chk("aw_none", 64'(aw_seen), 64'd0);
    if (beats > 0 && aw_addr_got.size() > 0) begin
      chk("aw_addr", 64'(aw_addr_got[0]), 64'(addr));
      chk("aw_len", 64'(aw_len_got[0]), 64'(beats - 1));
      chk("aw_size", 64'(aw_size_got), 64'd3);
      chk("aw_burst", 64'(aw_burst_got), 64'd1);
    end
    chk("w_beats", 64'(w_got.size()), 64'(beats));
    for (int i = 0; i < beats && i < w_got.size(); i++) begin
      chk("w_data", w_got[i], wr_exp[i]);
      chk("w_last", 64'(w_last_got[i]), 64'(i == beats - 1));
    end
    chk("w_pops", 64'(pops), 64'(beats));
    chk("wq_left", 64'(wq.size()), 64'(n - beats));
  endtask

  task automatic do_write(input int n, input logic [31:0] addr, input logic [1:0] resp,
                          input bit seq, input bit use_bp);
    int wr0;
    wr_prep(n, addr, resp, seq);
    bp = use_bp;
    wr0 = wr_rsp;
    req_pend = 2'b01;
    wait_done(wr0, rd_rsp, 1'b1, 1'b0);
    wr_check(n, addr, resp, wr0);
  endtask

  task automatic rd_prep(input int count, input logic [31:0] addr, input int stall, input bit rand_resp);
    ar_addr_got.delete(); ar_len_got.delete(); pushed.delete();
    r_sent.delete(); r_resp_sent.delete();
    rd_data_count_i = 10'(count);
    axi_rd_addr_i   = addr;
    rd_stall_arm    = stall;
    rd_rand_resp    = rand_resp;
  endtask

  task automatic rd_check(input int count, input logic [31:0] addr, input int rd0);
    int beats;
    logic [1:0] worst;
    beats = (count == 0) ? 1 : ((count > 256) ? 256 : count);
    worst = 2'b00;
    foreach (r_resp_sent[i]) if (r_resp_sent[i] > worst) worst = r_resp_sent[i];
    chk("rd_rsp_pulse", 64'(rd_rsp - rd0), 64'd1);
    chk("ar_count", 64'(ar_addr_got.size()), 64'd1);
    if (ar_addr_got.size() > 0) begin
      chk("ar_addr", 64'(ar_addr_got[0]), 64'(addr));
      chk("ar_len", 64'(ar_len_got[0]), 64'(beats - 1));
      chk("ar_size", 64'(ar_size_got), 64'd3);
      chk("ar_burst", 64'(ar_burst_got), 64'd1);
    end
    chk("rd_pushes", 64'(pushed.size()), 64'(beats));
    for (int i = 0; i < pushed.size() && i < r_sent.size(); i++)
      chk("rd_data", pushed[i], r_sent[i]);
    chk("rd_err", 64'(rd_err_o), 64'(worst));
  endtask

  task automatic do_read(input int count, input logic [31:0] addr, input int stall,
                         input bit rand_resp, input bit use_bp);
    int rd0;
    rd_prep(count, addr, stall, rand_resp);
    bp = use_bp;
    rd0 = rd_rsp;
    req_pend = 2'b10;
    wait_done(wr_rsp, rd0, 1'b0, 1'b1);
    rd_check(count, addr, rd0);
  endtask

  initial begin
    int wr0, rd0, t;
    rst_i = 1'b1; req_i = 2'b00; axi_wr_addr_i = '0; axi_rd_addr_i = '0;
    wr_fifo_gnt_i = 1'b0; rd_fifo_req_i = 1'b1; wr_fifo_data_i = '0;
    wr_data_count_i = '0; rd_data_count_i = '0;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
    bus.b_valid = 1'b0; bus.b_resp = 2'b00; bus.b_id = '0; bus.b_user = '0;
    bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = 2'b00; bus.r_last = 1'b0;
    bus.r_id = '0; bus.r_user = '0;
    rst_drv = 1'b1; req_pend = 2'b00; bp = 1'b0; b_pend = 1'b0; b_resp_cfg = 2'b00;
    rd_stall = 0; rd_stall_arm = 0; rd_rand_resp = 1'b0; r_hold = 1'b0;
    aw_stall = 1'b0; w_stall = 1'b0; pops = 0; aw_seen = 0; wr_rsp = 0; rd_rsp = 0;

    repeat (3) step();
    chk("rst_outputs", 64'({bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready,
                            rsp_o, wr_err_o, rd_err_o, wr_fifo_req_o, rd_fifo_gnt_o}), 64'd0);
    rst_drv = 1'b0;
    repeat (2) step();
    wr_rsp = 0; rd_rsp = 0;

    do_write(1, 32'h5000, 2'b00, 1'b1, 1'b0);
    do_write(5, 32'h5100, 2'b00, 1'b1, 1'b0);
    do_write(12, $urandom, 2'b00, 1'b0, 1'b1);
    do_write(3, 32'h5200, 2'b10, 1'b0, 1'b1);
    do_write(0, 32'h5300, 2'b00, 1'b0, 1'b0);
    do_write(300, 32'h5400, 2'b01, 1'b0, 1'b0);

    do_read(4, 32'h6000, 3, 1'b0, 1'b0);
    do_read(0, 32'h6100, 0, 1'b0, 1'b0);
    do_read(7, $urandom, 2, 1'b1, 1'b1);

    // Both directions started by the same request.
    wr_prep(3, 32'h7000, 2'b00, 1'b0);
    rd_prep(2, 32'h7800, 0, 1'b1);
    bp = 1'b1;
    wr0 = wr_rsp; rd0 = rd_rsp;
    req_pend = 2'b11;
    wait_done(wr0, rd0, 1'b1, 1'b1);
    wr_check(3, 32'h7000, 2'b00, wr0);
    rd_check(2, 32'h7800, rd0);

    // Reset while the write burst is in its data phase.
    wr_prep(8, 32'h8000, 2'b00, 1'b0);
    bp = 1'b1;
    wr0 = wr_rsp;
    req_pend = 2'b01;
    t = 0;
    while (w_got.size() < 2 && t < 500) begin
      step();
      t++;
    end
    chk("mid_w_timeout", 64'(t < 500), 64'd1);
    rst_drv = 1'b1;
    step();
    step();
    chk("mid_rst_outputs", 64'({bus.aw_valid, bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready,
                                rsp_o, wr_err_o, rd_err_o, wr_fifo_req_o, rd_fifo_gnt_o}), 64'd0);
    rst_drv = 1'b0;
    repeat (4) step();
    chk("mid_rst_no_rsp", 64'(wr_rsp - wr0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi4_fifo_mgr.md
Name: axi4_fifo_mgr

Overview:
- Generic AXI4 manager that moves data between local FIFOs and an AXI4 subordinate.
- A write request drains the write FIFO as a single INCR burst to a configured address.
- A read request fills the read FIFO from a single INCR burst at a configured address.
- Sits between the team's fifo_v3 instances and an axi4_bus_if manager port. Completion and error status are returned per direction.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width; must equal 8*AXI_XSIZE.
- AXI_XSIZE, 8, bytes per beat; ax_size = $clog2(AXI_XSIZE).
- DATA_COUNT_WIDTH, 10, width of the FIFO usage counts.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  2  bit0 = start write burst, bit1 = start read burst; single-cycle pulses.
- axi_wr_addr_i  in  AXI_ADDR_WIDTH  write burst start address.
- axi_rd_addr_i  in  AXI_ADDR_WIDTH  read burst start address.
- wr_fifo_gnt_i  in  1  write FIFO holds data (= !empty).
- rd_fifo_req_i  in  1  read FIFO can accept data (= !full).
- wr_fifo_data_i  in  AXI_DATA_WIDTH  write FIFO head (non-fall-through).
- wr_data_count_i  in  DATA_COUNT_WIDTH  write FIFO occupancy.
- rd_data_count_i  in  DATA_COUNT_WIDTH  requested read beat count.
- rsp_o  out  2  bit0 = write done pulse, bit1 = read done pulse.
- wr_err_o  out  2  latched BRESP of the last write.
- rd_err_o  out  2  latched worst RRESP of the last read.
- wr_fifo_req_o  out  1  pop write FIFO.
- rd_fifo_gnt_o  out  1  push read FIFO.
- rd_fifo_data_o  out  AXI_DATA_WIDTH  data to push.
- axi_mgr_if  interface  axi4_bus_if  manager side of the AW/W/B/AR/R channels.

Behaviour:
- Reset: all outputs 0, including every AXI valid/ready, rsp_o, err outputs and FIFO strobes. Both FSMs go to IDLE.
- Write and read FSMs are independent and may run concurrently; req_i=2'b11 starts both.
- A request arriving while its FSM is not in IDLE is ignored.
- Constant AXI fields: id=0, lock=0, cache=0, prot=0, qos=0, region=0, user=0, aw_atop=0, w_strb all ones, burst=INCR(2'b01), size=$clog2(AXI_XSIZE).
- Write FSM, states IDLE -> AW -> W -> B -> IDLE:
  - IDLE, req_i[0]: capture address; beats = min(wr_data_count_i, 256).
  - If beats = 0: no AXI traffic; rsp_o[0] pulses next cycle; wr_err_o = 0.
  - AW: aw_valid rises the cycle after the request, aw_len = beats-1. aw_valid holds until aw_ready; then go to W.
  - W: w_valid = wr_fifo_gnt_i and w_data = wr_fifo_data_i.
  - W: wr_fifo_req_o = w_valid & w_ready, so exactly one pop per accepted beat.
  - W: w_last is asserted on the final beat; leaving W follows the accepted last beat.
  - B: b_ready = 1; on b_valid, latch b_resp into wr_err_o, pulse rsp_o[0] for one cycle, return to IDLE.
- Read FSM, states IDLE -> AR -> R -> IDLE:
  - IDLE, req_i[1]: beats = min(max(rd_data_count_i, 1), 256).
  - AR: ar_len = beats-1; ar_valid holds until ar_ready.
  - R: r_ready = rd_fifo_req_i; rd_fifo_gnt_o = r_valid & r_ready; rd_fifo_data_o = r_data (combinational).
  - R: rd_err_o accumulates the maximum r_resp, cleared at request.
  - R: on an accepted beat with r_last, pulse rsp_o[1] and return to IDLE.
- Handshakes: valid is never dropped before ready. Payload is stable while valid and not ready.
- The write FIFO empty mid-burst stalls W (w_valid low); no timeout.
- Reset mid-burst aborts immediately to IDLE with no completion pulse.
- Errors hold their value until the next request of the same direction.

Test Plan:
- Write 1 beat: push 1 word (0x0), wr_data_count=1, addr 0x5000, req_i=01.
  - Expect AW addr 0x5000, len 0, size 3, burst 1.
  - Expect one W beat data 0x0 with w_last=1 and one pop.
  - B OKAY -> rsp_o[0] one-cycle pulse, wr_err_o=00.
- Write 5 beats: push 0..4, req_i=01 -> len 4; W data 0,1,2,3,4; w_last only on 4; 5 pops; FIFO empty at end.
- Subordinate backpressure: w_ready and aw_ready toggle randomly -> no beat lost or duplicated; payload stable while stalled.
- B SLVERR (2'b10) -> wr_err_o=10 and rsp_o[0] pulse. A zero-count write -> rsp_o[0] pulse and no aw_valid.
- Read 4 beats, addr 0x6000: rd_data_count=4, req_i=10.
  - Expect AR len 3.
  - Read FIFO full for 3 cycles mid-burst -> r_ready low during stall; 4 pushes in order.
  - rsp_o[1] after r_last.
- Concurrent: req_i=11 -> both bursts complete with independent rsp pulses. Reset asserted during W -> all outputs 0 next cycle.
